// File: rtl/dds_spi_loader.sv
// dds_spi_loader: deserialises the slow serial control bus into the DDS frequency tuning word
// and phase-shift word. Serial inputs are asynchronous to sys_clk and are resynchronised here.
//
// Ports:
//   sys_clk, sys_rst         system clock, synchronous active-high reset
//   spi_clk, spi_data        serial clock (data captured on its rise) and MSB-first data
//   freq_cs, phaseshift_cs   active-high transfer selects
//   freq_word, freq_load     committed frequency word and its one-cycle load strobe
//   phase_word, phase_load   committed phase word and its one-cycle load strobe
//   xfer_error               sticky: both selects were active together
module dds_spi_loader #(
  parameter int unsigned PHASE_LENGTH = 16,
  parameter int unsigned ACC_LENGTH   = 48,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    spi_clk,
  input  logic                    spi_data,
  input  logic                    freq_cs,
  input  logic                    phaseshift_cs,
  output logic [ACC_LENGTH-1:0]   freq_word,
  output logic                    freq_load,
  output logic [PHASE_LENGTH-1:0] phase_word,
  output logic                    phase_load,
  output logic                    xfer_error
);

  localparam int unsigned NbW = $clog2(ACC_LENGTH + 1);

  typedef enum logic [2:0] {StIdle, StShiftF, StShiftP, StCommitF, StCommitP, StErr} state_e;

  // Bit order in the synchroniser bus: {phaseshift_cs, freq_cs, spi_data, spi_clk}
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  lvl;
  // History only for the signals whose edges matter: {phaseshift_cs, freq_cs, spi_clk}
  logic [2:0]                  hist_q;
  // Marks when every sync/history flop holds a real sample after reset
  logic [SYNC_STAGES:0]        vld_q;
  // A select may start a transfer only after it has been seen low since reset
  logic                        f_armed_q, p_armed_q;

  logic clk_rise, f_rise, f_fall, p_rise, p_fall;

  assign lvl      = sync_q[SYNC_STAGES-1];
  assign clk_rise = lvl[0] & ~hist_q[0];
  assign f_rise   = lvl[2] & ~hist_q[1];
  assign f_fall   = ~lvl[2] & hist_q[1];
  assign p_rise   = lvl[3] & ~hist_q[2];
  assign p_fall   = ~lvl[3] & hist_q[2];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q    <= '0;
      hist_q    <= '0;
      vld_q     <= '0;
      f_armed_q <= 1'b0;
      p_armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {phaseshift_cs, freq_cs, spi_data, spi_clk}};
      hist_q <= {lvl[3], lvl[2], lvl[0]};
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      if (vld_q[SYNC_STAGES] && !lvl[2]) f_armed_q <= 1'b1;
      if (vld_q[SYNC_STAGES] && !lvl[3]) p_armed_q <= 1'b1;
    end
  end

  state_e                  state_q, state_d;
  logic [ACC_LENGTH-1:0]   sh_q;
  logic [NbW-1:0]          nbits_q;
  logic                    clr, shift_en, commit_f, commit_p, err_set;

  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    commit_f = 1'b0;
    commit_p = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lvl[2] && lvl[3]) begin
          state_d = StErr;
        end else if (f_rise && f_armed_q) begin
          state_d = StShiftF;
          clr     = 1'b1;
        end else if (p_rise && p_armed_q) begin
          state_d = StShiftP;
          clr     = 1'b1;
        end
      end
      StShiftF: begin
        if (lvl[3]) begin
          state_d = StErr;
        end else begin
          shift_en = clk_rise;
          // A bit arriving with the select fall still counts toward a non-empty word
          if (f_fall) state_d = (nbits_q != '0 || clk_rise) ? StCommitF : StIdle;
        end
      end
      StShiftP: begin
        if (lvl[2]) begin
          state_d = StErr;
        end else begin
          shift_en = clk_rise;
          if (p_fall) state_d = (nbits_q != '0 || clk_rise) ? StCommitP : StIdle;
        end
      end
      StCommitF: begin
        commit_f = 1'b1;
        state_d  = StIdle;
      end
      StCommitP: begin
        commit_p = 1'b1;
        state_d  = StIdle;
      end
      StErr: begin
        err_set = 1'b1;
        if (!lvl[2] && !lvl[3]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      nbits_q    <= '0;
      freq_word  <= '0;
      phase_word <= '0;
      freq_load  <= 1'b0;
      phase_load <= 1'b0;
      xfer_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_load  <= commit_f;
      phase_load <= commit_p;
      if (clr) begin
        sh_q    <= '0;
        nbits_q <= '0;
      end else if (shift_en) begin
        sh_q <= {sh_q[ACC_LENGTH-2:0], lvl[1]};
        if (nbits_q != NbW'(ACC_LENGTH)) nbits_q <= nbits_q + NbW'(1);
      end
      if (commit_f) freq_word  <= sh_q;
      if (commit_p) phase_word <= sh_q[PHASE_LENGTH-1:0];
      if (err_set)  xfer_error <= 1'b1;
    end
  end

endmodule
